// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and controller state encoding for the PWM fade path
package pwm_pkg;
  localparam int DUTY_W_DEF = 8;
  localparam int HOLD_W_DEF = 8;
  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;
endpackage

// File: rtl/pwm_frame_timer.sv
// pwm_frame_timer: free-running PWM frame counter with last-clock-of-frame tick
module pwm_frame_timer #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);
  logic [W-1:0] frame_cnt;
  // count every clock and wrap naturally at the top of the frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + W'(1);
  assign frame_tick = &frame_cnt;
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps the PWM duty toward a commanded target at frame boundaries
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [DUTY_W-1:0] cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              frame_tick,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [DUTY_W-1:0] tgt, tgt_n, step_r, step_n, duty_n, diff;
  logic [HOLD_W-1:0] hold_r, hold_n, hcnt, hcnt_n;
  logic done_n, up;
  pwm_frame_timer #(.W(DUTY_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick)
  );
  assign cmd_ready = state == IDLE;
  assign busy = state == RAMP;
  assign up = tgt > duty;
  assign diff = up ? tgt - duty : duty - tgt;
  // next-state: latch commands in IDLE, step or abort in RAMP; a final step lands exactly on target
  always_comb begin
    state_n = state;
    tgt_n = tgt;
    step_n = step_r;
    hold_n = hold_r;
    hcnt_n = hcnt;
    duty_n = duty;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (cmd_valid) begin
        tgt_n = cmd_target;
        step_n = cmd_step == '0 ? DUTY_W'(1) : cmd_step;
        hold_n = cmd_hold == '0 ? HOLD_W'(1) : cmd_hold;
        hcnt_n = hold_n;
        done_n = cmd_target == duty;
        state_n = cmd_target == duty ? IDLE : RAMP;
      end
    end else if (abort) begin
      state_n = IDLE;
    end else if (frame_tick) begin
      if (hcnt > HOLD_W'(1)) begin
        hcnt_n = hcnt - HOLD_W'(1);
      end else begin
        hcnt_n = hold_r;
        duty_n = diff <= step_r ? tgt : (up ? duty + step_r : duty - step_r);
        done_n = diff <= step_r;
        state_n = diff <= step_r ? IDLE : RAMP;
      end
    end
  end
  // state and datapath registers; reset forces duty to 0 immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tgt <= '0;
      step_r <= DUTY_W'(1);
      hold_r <= HOLD_W'(1);
      hcnt <= HOLD_W'(1);
      duty <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tgt <= tgt_n;
      step_r <= step_n;
      hold_r <= hold_n;
      hcnt <= hcnt_n;
      duty <= duty_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: table-driven ramp vectors plus abort, hold-off and reset sequences
module tb_pwm_fade_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0;
  logic [7:0] cmd_target = '0, cmd_step = '0, cmd_hold = '0;
  logic cmd_ready, frame_tick, busy, done;
  logic [7:0] duty;
  int checks = 0, errors = 0;

  typedef struct {
    logic [7:0] tgt;
    logic [7:0] stp;
    logic [7:0] hld;
    int exp_first;
    int exp_final;
    int exp_frames;
  } vec_t;
  vec_t vecs[8];

  pwm_fade_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_hold(cmd_hold),
    .abort(abort), .duty(duty), .frame_tick(frame_tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [7:0] h);
    cmd_valid = 1'b1;
    cmd_target = t;
    cmd_step = s;
    cmd_hold = h;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ticks = 0, first = -1, cyc = 0, budget;
    bit got = 0, busy_seen = 0, bad_edge = 0, pt = 0;
    logic [7:0] pd;
    budget = v.exp_frames * 256 + 600;
    pd = duty;
    send(v.tgt, v.stp, v.hld);
    while (!got && cyc < budget) begin
      if (duty != pd) begin
        if (!pt) bad_edge = 1;
        if (first < 0) first = int'(duty);
      end
      if (busy) busy_seen = 1;
      if (done) got = 1;
      else begin
        if (frame_tick) ticks++;
        pt = frame_tick;
        pd = duty;
        @(negedge clk);
        cyc++;
      end
    end
    chk($sformatf("v%0d done_seen", idx), int'(got), 1);
    chk($sformatf("v%0d final_duty", idx), int'(duty), v.exp_final);
    chk($sformatf("v%0d first_step", idx), first, v.exp_first);
    chk($sformatf("v%0d frames", idx), ticks, v.exp_frames);
    chk($sformatf("v%0d ready_at_done", idx), int'(cmd_ready), 1);
    chk($sformatf("v%0d busy_seen", idx), int'(busy_seen), int'(v.exp_frames > 0));
    chk($sformatf("v%0d step_off_frame", idx), int'(bad_edge), 0);
    if (v.exp_frames == 0) chk($sformatf("v%0d noop_latency", idx), cyc, 0);
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", idx), int'(done), 0);
  endtask

  initial begin
    int n, first_tick, second_tick, done_cnt;
    bit bad_idle, held_ok;
    logic [7:0] pre;
    vecs[0] = '{8'd100, 8'd30,  8'd1, 30,  100, 4};
    vecs[1] = '{8'd200, 8'd50,  8'd3, 150, 200, 6};
    vecs[2] = '{8'd185, 8'd0,   8'd2, 199, 185, 30};
    vecs[3] = '{8'd250, 8'd255, 8'd0, 250, 250, 1};
    vecs[4] = '{8'd255, 8'd20,  8'd1, 255, 255, 1};
    vecs[5] = '{8'd255, 8'd7,   8'd4, -1,  255, 0};
    vecs[6] = '{8'd0,   8'd100, 8'd1, 155, 0,   3};
    vecs[7] = '{8'd0,   8'd3,   8'd5, -1,  0,   0};

    #2;
    chk("rst_duty", int'(duty), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tick", int'(frame_tick), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bad_idle = 0; done_cnt = 0; first_tick = -1; second_tick = -1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (duty != 8'd0 || !cmd_ready || busy) bad_idle = 1;
      if (done) done_cnt++;
      if (frame_tick) begin
        if (first_tick < 0) first_tick = k;
        else if (second_tick < 0) second_tick = k;
      end
    end
    chk("idle_state", int'(bad_idle), 0);
    chk("idle_done", done_cnt, 0);
    chk("idle_tick1", first_tick, 255);
    chk("idle_tick2", second_tick, 511);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    send(8'd200, 8'd10, 8'd1);
    n = 0;
    while (duty != 8'd10 && n < 600) begin @(negedge clk); n++; end
    chk("ab_first_step", int'(duty), 10);
    cmd_valid = 1'b1; cmd_target = 8'd12; cmd_step = 8'd0; cmd_hold = 8'd1;
    held_ok = 1; n = 0;
    @(negedge clk);
    while (!frame_tick && n < 300) begin
      if (cmd_ready || !busy) held_ok = 0;
      @(negedge clk);
      n++;
    end
    chk("ab_held_off", int'(held_ok), 1);
    chk("ab_tick_found", int'(frame_tick), 1);
    pre = duty;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_duty_frozen", int'(duty), int'(pre));
    chk("ab_duty_value", int'(duty), 10);
    chk("ab_no_done", int'(done), 0);
    chk("ab_ready", int'(cmd_ready), 1);
    chk("ab_busy", int'(busy), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ab_held_cmd_accepted", int'(busy), 1);
    n = 0;
    while (!done && n < 1200) begin @(negedge clk); n++; end
    chk("ab_held_cmd_done", int'(done), 1);
    chk("ab_held_cmd_duty", int'(duty), 12);

    @(negedge clk);
    send(8'd250, 8'd5, 8'd1);
    repeat (600) @(negedge clk);
    chk("rs_ramping", int'(busy), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rs_duty", int'(duty), 0);
    chk("rs_busy", int'(busy), 0);
    chk("rs_ready", int'(cmd_ready), 1);
    chk("rs_tick", int'(frame_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_tick && n < 300);
    chk("rs_frame_restart", n, 255);
    chk("rs_duty_after", int'(duty), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
